demux_lane_scheduler: RTL

Sequencer for the 1-to-4 demultiplexer datapath. It accepts a serial bit stream under a valid/ready handshake and drives the demux select so each bit goes to the next enabled output lane in round-robin order. It counts bits per burst and signals completion. It sits between a serial bit source and four lane consumers, and owns the demux select that a test bench otherwise drives by hand.

---
 rtl/demux_sched_pkg.sv | 30 +++
 rtl/lane_demux4.sv | 21 ++
 rtl/demux_lane_scheduler.sv | 108 ++++++++++
 3 files changed

// File: rtl/demux_sched_pkg.sv
// Shared types and lane-selection helpers for the 1-to-4 demux lane scheduler.
package demux_sched_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DONE
  } state_t;

  // Nearest enabled lane above cur, wrapping 3->0. Keeps cur when no other lane is enabled.
  function automatic logic [1:0] next_lane(input logic [NUM_LANES-1:0] mask,
                                           input logic [1:0] cur);
    logic [1:0] idx;
    logic [1:0] res;
    res = cur;
    for (int i = NUM_LANES - 1; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

  // Lowest enabled lane, used as the first lane of a burst.
  function automatic logic [1:0] first_lane(input logic [NUM_LANES-1:0] mask);
    return next_lane(mask, 2'd3);
  endfunction

endpackage

// File: rtl/lane_demux4.sv
// Combinational 1-to-4 demux with a one-hot enable of the selected lane.
module lane_demux4
  import demux_sched_pkg::*;
(
  input  logic                 data_i,
  input  logic [1:0]           sel_i,
  input  logic                 en_i,
  output logic [NUM_LANES-1:0] data_o,
  output logic [NUM_LANES-1:0] strobe_o
);

  always_comb begin
    data_o   = '0;
    strobe_o = '0;
    if (en_i) begin
      data_o[sel_i]   = data_i;
      strobe_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_lane_scheduler.sv
// Round-robin scheduler that routes an accepted serial bit stream to the enabled demux lanes.
module demux_lane_scheduler
  import demux_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic [CNT_W-1:0]     burst_len,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  output logic [1:0]           sel,
  output logic [NUM_LANES-1:0] lane_out,
  output logic [NUM_LANES-1:0] lane_strobe,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t                 state_q;
  logic [1:0]             sel_q;
  logic [NUM_LANES-1:0]   lane_out_q;
  logic [NUM_LANES-1:0]   strobe_q;
  logic                   done_q;
  logic                   err_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_LANES-1:0]   mask_q;
  logic [CNT_W-1:0]       len_q;

  logic                   accept;
  logic [CNT_W-1:0]       cnt_d;
  logic [NUM_LANES-1:0]   dmx_data;
  logic [NUM_LANES-1:0]   dmx_stb;

  assign in_ready = (state_q == DISPATCH);
  assign busy     = (state_q == DISPATCH);
  assign accept   = in_valid && in_ready;
  assign cnt_d    = cnt_q + 1'b1;

  lane_demux4 u_demux (
    .data_i   (in_bit),
    .sel_i    (sel_q),
    .en_i     (accept),
    .data_o   (dmx_data),
    .strobe_o (dmx_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      lane_out_q <= '0;
      strobe_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      mask_q     <= '0;
      len_q      <= '0;
    end else begin
      strobe_q   <= dmx_stb;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      // Only the strobed lane takes the new bit; the others hold their last delivered value.
      lane_out_q <= (lane_out_q & ~dmx_stb) | dmx_data;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (lane_en == '0) begin
              err_q <= 1'b1;
            end else begin
              mask_q <= lane_en;
              len_q  <= burst_len;
              cnt_q  <= '0;
              if (burst_len == '0) begin
                state_q <= DONE;
              end else begin
                sel_q   <= first_lane(lane_en);
                state_q <= DISPATCH;
              end
            end
          end
        end
        DISPATCH: begin
          if (accept) begin
            cnt_q <= cnt_d;
            sel_q <= next_lane(mask_q, sel_q);
            if (cnt_d == len_q) state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel         = sel_q;
  assign lane_out    = lane_out_q;
  assign lane_strobe = strobe_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
